state_mux_reg: RTL and testbench
================================

Name: state_mux_reg

Overview:
Parametrised, registered successor to the ASCON two-input state multiplexer. Arbitrates among N_SRC 320-bit state sources, e.g. a fresh init state, the permutation loopback and a finalisation reload. It optionally XOR-absorbs a rate-wide data block into the selected state and holds the result in an output register behind a valid/ready handshake. It sits between the FSM-driven state sources and the permutation core input.

Parameters:
WIDTH, 320, state width in bits (type_state size).
N_SRC, 3, number of state sources, minimum 2.
RATE, 64, absorb width: 64 for ASCON-128, 128 for ASCON-128a; RATE must be ≤ WIDTH.
ARB_RR, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
clock_i  input  1  system clock, rising edge.
resetb_i  input  1  reset, asynchronous, active-low.
src_state_i  input  N_SRC*WIDTH  packed source states; source k occupies bits [k*WIDTH +: WIDTH].
src_valid_i  input  N_SRC  per-source valid.
src_ready_o  output  N_SRC  per-source ready; one-hot or zero.
xor_en_i  input  1  XOR xor_data_i into the accepted state.
xor_data_i  input  RATE  data block to absorb.
flush_i  input  1  synchronous clear of the output register and arbiter.
state_o  output  WIDTH  registered selected state.
state_valid_o  output  1  state_o holds a valid state.
state_ready_i  input  1  downstream consumes state_o.
grant_o  output  IDX_W  index of the source that loaded state_o, where IDX_W = max(1, $clog2(N_SRC)).

Behaviour:
- Reset (resetb_i=0, asynchronous): state_o=0, state_valid_o=0, grant_o=0, round-robin pointer=0. Reset mid-transfer discards the held state; there is no partial state.
- load_en = !state_valid_o || state_ready_i. The block accepts a new state only when load_en is high.
- Arbitration runs among the asserted src_valid_i bits.
  - ARB_RR=0: the lowest index wins.
  - ARB_RR=1: search starts at the pointer and wraps modulo N_SRC. The pointer updates to (winner+1) mod N_SRC only on an accept. The pointer wraps from N_SRC-1 to 0.
- src_ready_o[k] = load_en && !flush_i && (k == winner) && src_valid_i[k]. This path is combinational. All ready bits are 0 when no source is valid.
- Accept (any ready bit high): on the next edge state_o = selected state, with bits [WIDTH-1 -: RATE] XORed with xor_data_i if xor_en_i is high. Lower bits are unchanged. state_valid_o=1 and grant_o=winner.
- Latency is 1 cycle from accept to state_valid_o.
- Throughput is 1 state per cycle while state_ready_i is held high.
- Hold: if state_valid_o=1 and state_ready_i=0, state_o, grant_o and state_valid_o stay stable and every src_ready_o is 0.
- Consume with no new valid source: state_valid_o goes to 0 next cycle. state_o keeps its last value.
- Simultaneous consume and accept: the new state is loaded and state_valid_o stays 1 with no bubble.
- xor_en_i without an accept is ignored and nothing is buffered.
- flush_i: highest priority after reset. It forces state_valid_o=0 and the pointer to 0 next cycle, with no accept that cycle. state_o and grant_o keep their values.
- Inputs are sampled only on accept. Source data may change while its ready bit is 0.

Test Plan:
1. Reset, then N_SRC=3, ARB_RR=0, src_valid_i=3'b110, src1=320'hA..A, src2=320'h5..5, state_ready_i=1 → src_ready_o=3'b010; next cycle state_o=A..A, grant_o=1, state_valid_o=1.
2. Backpressure: state_ready_i=0 for 4 cycles with src_valid_i=3'b001 → src_ready_o=0 and state_o stable for all 4 cycles. Raise state_ready_i → src0 is loaded the cycle after, with no bubble and state_valid_o staying 1.
3. Absorb: src0=0, xor_en_i=1, xor_data_i=64'h0123456789ABCDEF, RATE=64 → state_o[319:256]=64'h0123456789ABCDEF and state_o[255:0]=0. With RATE=128 and xor_data_i of all ones → the top 128 bits are ones.
4. ARB_RR=1, all 3 sources valid for 6 cycles, state_ready_i=1 → grant_o sequence 0,1,2,0,1,2. Drop src1 → the sequence skips 1.
5. flush_i asserted while state_valid_o=1 and src_valid_i=3'b001 → no src_ready_o that cycle; next cycle state_valid_o=0 and the pointer is 0.
6. resetb_i pulsed low asynchronously mid-stream, between clock edges → state_valid_o=0 and state_o=0 immediately. After release, the first grant is index 0.

Source files
------------

// File: rtl/state_mux_reg.sv
// Registered N-source state multiplexer with optional rate absorb, ahead of the permutation core.
// Fixed-priority or round-robin arbitration; one state buffered behind a valid/ready handshake.
module state_mux_reg #(
  parameter  int WIDTH  = 320,
  parameter  int N_SRC  = 3,
  parameter  int RATE   = 64,
  parameter  int ARB_RR = 0,
  localparam int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clock_i,
  input  logic                   resetb_i,
  input  logic [N_SRC*WIDTH-1:0] src_state_i,
  input  logic [N_SRC-1:0]       src_valid_i,
  output logic [N_SRC-1:0]       src_ready_o,
  input  logic                   xor_en_i,
  input  logic [RATE-1:0]        xor_data_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       state_o,
  output logic                   state_valid_o,
  input  logic                   state_ready_i,
  output logic [IDX_W-1:0]       grant_o
);

  logic [WIDTH-1:0] r_state;
  logic             r_valid;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_ptr;

  logic             w_load_en;
  logic             w_accept;
  logic             w_found;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_next_ptr;
  logic [N_SRC-1:0] w_ready;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_absorb;
  logic [WIDTH-1:0] w_next_state;

  // (base + off) mod N_SRC, with off always below N_SRC
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_SRC) s = s - N_SRC;
    return IDX_W'(s);
  endfunction

  assign w_load_en = !r_valid || state_ready_i;

  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!w_found) begin
        w_cand = (ARB_RR != 0) ? wrap_idx(r_ptr, i) : IDX_W'(i);
        if (src_valid_i[w_cand]) begin
          w_winner = w_cand;
          w_found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_load_en && !flush_i && w_found) w_ready[w_winner] = 1'b1;
  end

  assign w_accept    = |w_ready;
  assign src_ready_o = w_ready;
  assign w_next_ptr  = wrap_idx(w_winner, 1);

  // Absorbed block lands in the most significant RATE bits of the state
  assign w_sel        = src_state_i[int'(w_winner)*WIDTH +: WIDTH];
  assign w_absorb     = xor_en_i ? (WIDTH'(xor_data_i) << (WIDTH - RATE)) : '0;
  assign w_next_state = w_sel ^ w_absorb;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_state <= w_next_state;
      r_valid <= 1'b1;
      r_grant <= w_winner;
      r_ptr   <= w_next_ptr;
    end else if (state_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign state_o       = r_state;
  assign state_valid_o = r_valid;
  assign grant_o       = r_grant;

endmodule

// File: tb/tb_state_mux_reg.sv
// Bench for state_mux_reg: three instances (fixed/64, round-robin/64, fixed/128) share stimulus
// and are checked against a per-instance behavioural model.
module tb_state_mux_reg;

  localparam int W = 320;
  localparam int N = 3;

  logic           clk;
  logic           rstb;
  logic [N*W-1:0] src_state;
  logic [N-1:0]   src_valid;
  logic           xor_en;
  logic [127:0]   x128;
  logic           flush;
  logic           sready;

  logic [N-1:0]   rdy [3];
  logic [W-1:0]   st  [3];
  logic           vld [3];
  logic [1:0]     gnt [3];

  int n_pass  = 0;
  int n_total = 0;

  // model state
  int           m_rr   [3] = '{0, 1, 0};
  int           m_rate [3] = '{64, 64, 128};
  logic         m_valid[3];
  logic [W-1:0] m_state[3];
  int           m_grant[3];
  int           m_ptr  [3];
  logic [N-1:0] exp_rdy[3];
  logic [N-1:0] obs_rdy[3];
  int           exp_w  [3];

  state_mux_reg #(.WIDTH(W), .N_SRC(N), .RATE(64), .ARB_RR(0)) dut_fp (
    .clock_i(clk), .resetb_i(rstb), .src_state_i(src_state), .src_valid_i(src_valid),
    .src_ready_o(rdy[0]), .xor_en_i(xor_en), .xor_data_i(x128[63:0]), .flush_i(flush),
    .state_o(st[0]), .state_valid_o(vld[0]), .state_ready_i(sready), .grant_o(gnt[0]));

  state_mux_reg #(.WIDTH(W), .N_SRC(N), .RATE(64), .ARB_RR(1)) dut_rr (
    .clock_i(clk), .resetb_i(rstb), .src_state_i(src_state), .src_valid_i(src_valid),
    .src_ready_o(rdy[1]), .xor_en_i(xor_en), .xor_data_i(x128[63:0]), .flush_i(flush),
    .state_o(st[1]), .state_valid_o(vld[1]), .state_ready_i(sready), .grant_o(gnt[1]));

  state_mux_reg #(.WIDTH(W), .N_SRC(N), .RATE(128), .ARB_RR(0)) dut_r128 (
    .clock_i(clk), .resetb_i(rstb), .src_state_i(src_state), .src_valid_i(src_valid),
    .src_ready_o(rdy[2]), .xor_en_i(xor_en), .xor_data_i(x128), .flush_i(flush),
    .state_o(st[2]), .state_valid_o(vld[2]), .state_ready_i(sready), .grant_o(gnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand320();
    logic [W-1:0] r;
    for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int model_winner(int i);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr[i] != 0) ? (m_ptr[i] + k) % N : k;
      if (src_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] model_mask(int i);
    if (!xor_en) return '0;
    if (m_rate[i] == 64) return {x128[63:0], 256'd0};
    return {x128, 192'd0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_state[i] = '0;
      m_grant[i] = 0;
      m_ptr[i]   = 0;
    end
  endtask

  // Samples ready before the edge, advances one clock, updates the model; ends 1 time unit after the edge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      obs_rdy[i] = rdy[i];
      exp_w[i]   = model_winner(i);
      exp_rdy[i] = '0;
      if ((!m_valid[i] || sready) && !flush && exp_w[i] >= 0) exp_rdy[i][exp_w[i]] = 1'b1;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (flush) begin
        m_valid[i] = 1'b0;
        m_ptr[i]   = 0;
      end else if (exp_rdy[i] != '0) begin
        m_state[i] = src_state[exp_w[i]*W +: W] ^ model_mask(i);
        m_valid[i] = 1'b1;
        m_grant[i] = exp_w[i];
        m_ptr[i]   = (exp_w[i] + 1) % N;
      end else if (sready) begin
        m_valid[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rstb = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (vld[i] !== 1'b0) $display("FAIL reset_valid[%0d] got=%b exp=0", i, vld[i]); else n_pass++;
      n_total++;
      if (st[i] !== '0) $display("FAIL reset_state[%0d] got=%h exp=0", i, st[i]); else n_pass++;
      n_total++;
      if (gnt[i] !== 2'd0) $display("FAIL reset_grant[%0d] got=%0d exp=0", i, gnt[i]); else n_pass++;
    end
  endtask

  task automatic test_fixed_priority();
    src_state = {{40{8'h55}}, {40{8'hAA}}, rand320()};
    src_valid = 3'b110;
    sready = 1'b1;
    tick();
    n_total++;
    if (obs_rdy[0] !== 3'b010) $display("FAIL fp_ready got=%b exp=010", obs_rdy[0]); else n_pass++;
    n_total++;
    if (st[0] !== {40{8'hAA}}) $display("FAIL fp_state got=%h exp=%h", st[0], {40{8'hAA}}); else n_pass++;
    n_total++;
    if (gnt[0] !== 2'd1) $display("FAIL fp_grant got=%0d exp=1", gnt[0]); else n_pass++;
    n_total++;
    if (vld[0] !== 1'b1) $display("FAIL fp_valid got=%b exp=1", vld[0]); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r0;
    r0 = rand320();
    src_state = {rand320(), rand320(), r0};
    src_valid = 3'b001;
    sready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_total++;
      if (obs_rdy[0] !== 3'b000) $display("FAIL bp_ready c%0d got=%b exp=000", c, obs_rdy[0]); else n_pass++;
      n_total++;
      if (st[0] !== {40{8'hAA}} || vld[0] !== 1'b1)
        $display("FAIL bp_hold c%0d got=%h/%b exp=%h/1", c, st[0], vld[0], {40{8'hAA}});
      else n_pass++;
    end
    sready = 1'b1;
    tick();
    n_total++;
    if (obs_rdy[0] !== 3'b001) $display("FAIL bp_release_ready got=%b exp=001", obs_rdy[0]); else n_pass++;
    n_total++;
    if (st[0] !== r0 || vld[0] !== 1'b1 || gnt[0] !== 2'd0)
      $display("FAIL bp_release_load got=%h/%b/%0d exp=%h/1/0", st[0], vld[0], gnt[0], r0);
    else n_pass++;
  endtask

  task automatic test_absorb();
    src_state = {rand320(), rand320(), {W{1'b0}}};
    src_valid = 3'b001;
    sready = 1'b1;
    xor_en = 1'b1;
    x128 = {64'h0, 64'h0123456789ABCDEF};
    tick();
    n_total++;
    if (st[0] !== {64'h0123456789ABCDEF, 256'd0})
      $display("FAIL absorb64 got=%h exp=%h", st[0], {64'h0123456789ABCDEF, 256'd0});
    else n_pass++;
    x128 = {128{1'b1}};
    tick();
    n_total++;
    if (st[2] !== {{128{1'b1}}, 192'd0})
      $display("FAIL absorb128 got=%h exp=%h", st[2], {{128{1'b1}}, 192'd0});
    else n_pass++;
    xor_en = 1'b0;
  endtask

  task automatic test_round_robin();
    int seq_a[6] = '{0, 1, 2, 0, 1, 2};
    int seq_b[4] = '{0, 2, 0, 2};
    do_reset();
    src_valid = 3'b111;
    sready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      src_state = {rand320(), rand320(), rand320()};
      tick();
      n_total++;
      if (gnt[1] !== 2'(seq_a[c])) $display("FAIL rr_all c%0d got=%0d exp=%0d", c, gnt[1], seq_a[c]); else n_pass++;
    end
    src_valid = 3'b101;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_total++;
      if (gnt[1] !== 2'(seq_b[c])) $display("FAIL rr_skip c%0d got=%0d exp=%0d", c, gnt[1], seq_b[c]); else n_pass++;
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] kept;
    src_valid = 3'b001;
    sready = 1'b1;
    tick();
    kept = m_state[0];
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_total++;
    if (obs_rdy[0] !== 3'b000 || obs_rdy[1] !== 3'b000)
      $display("FAIL flush_ready got=%b/%b exp=000/000", obs_rdy[0], obs_rdy[1]);
    else n_pass++;
    n_total++;
    if (vld[0] !== 1'b0 || vld[1] !== 1'b0) $display("FAIL flush_valid got=%b/%b exp=0/0", vld[0], vld[1]); else n_pass++;
    n_total++;
    if (st[0] !== kept) $display("FAIL flush_keep got=%h exp=%h", st[0], kept); else n_pass++;
    src_valid = 3'b111;
    tick();
    n_total++;
    if (gnt[1] !== 2'd0) $display("FAIL flush_ptr got=%0d exp=0", gnt[1]); else n_pass++;
  endtask

  task automatic test_async_reset();
    src_valid = 3'b111;
    sready = 1'b1;
    src_state = {rand320(), rand320(), rand320()};
    tick();
    tick();
    #2 rstb = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (vld[i] !== 1'b0 || st[i] !== '0)
        $display("FAIL async_reset[%0d] got=%b/%h exp=0/0", i, vld[i], st[i]);
      else n_pass++;
    end
    @(posedge clk);
    #3 rstb = 1'b1;
    src_valid = 3'b111;
    tick();
    n_total++;
    if (gnt[0] !== 2'd0 || gnt[1] !== 2'd0 || vld[1] !== 1'b1)
      $display("FAIL post_reset_grant got=%0d/%0d/%b exp=0/0/1", gnt[0], gnt[1], vld[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      src_state = {rand320(), rand320(), rand320()};
      src_valid = 3'($urandom_range(0, 7));
      sready    = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      xor_en    = 1'($urandom);
      x128      = {$urandom, $urandom, $urandom, $urandom};
      tick();
      for (int i = 0; i < 3; i++) begin
        n_total++;
        if (obs_rdy[i] !== exp_rdy[i])
          $display("FAIL rnd_ready[%0d] c%0d got=%b exp=%b", i, c, obs_rdy[i], exp_rdy[i]);
        else n_pass++;
        n_total++;
        if (vld[i] !== m_valid[i] || gnt[i] !== 2'(m_grant[i]))
          $display("FAIL rnd_vg[%0d] c%0d got=%b/%0d exp=%b/%0d", i, c, vld[i], gnt[i], m_valid[i], m_grant[i]);
        else n_pass++;
        n_total++;
        if (st[i] !== m_state[i])
          $display("FAIL rnd_state[%0d] c%0d got=%h exp=%h", i, c, st[i], m_state[i]);
        else n_pass++;
      end
    end
    flush = 1'b0;
    xor_en = 1'b0;
  endtask

  initial begin
    rstb = 1'b0;
    src_state = '0;
    src_valid = '0;
    xor_en = 1'b0;
    x128 = '0;
    flush = 1'b0;
    sready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    test_reset();
    test_fixed_priority();
    test_backpressure();
    test_absorb();
    test_round_robin();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
